// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants
// and the even-parity helper. The receive path imports the same package.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    TxIdle   = 3'd0,
    TxStart  = 3'd1,
    TxShift  = 3'd2,
    TxParity = 3'd3,
    TxStop   = 3'd4
  } tx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/uart_xmit_if.sv
// CPU-side write port and serial-line status of the UART transmitter.
interface uart_xmit_if;

  logic        WR;
  logic [31:0] Din;
  logic        TxD;
  logic        TxRDY;
  logic        TxBusy;

  modport master (output WR, Din, input TxD, TxRDY, TxBusy);
  modport slave  (input WR, Din, output TxD, TxRDY, TxBusy);

endinterface

// File: rtl/uart_xmit_baud_gen.sv
// Bit-period timer for the transmitter: counts 0..BAUD_DIV-1 and pulses
// o_tick on the last count of each bit. i_clr holds the counter at zero.
module uart_xmit_baud_gen #(
  parameter int BAUD_DIV = 16,
  parameter int CNT_W    = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_clr,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == CNT_W'(BAUD_DIV - 1));

  // Count cycles within a bit; wrap on the tick so every bit is BAUD_DIV long.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_xmit.sv
// UART transmitter: start bit, 8 data bits LSB-first, even parity, stop bit.
// Build option UART_XMIT_HOLD_REG_EN adds a one-byte holding register so a
// byte written during a frame follows it on the line with no idle gap.
//
// state    | meaning
// TxIdle   | line high, waiting for a write
// TxStart  | driving the start bit (0)
// TxShift  | driving data bits LSB-first
// TxParity | driving the even-parity bit
// TxStop   | driving the stop bit (1)
module uart_xmit
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 16,
  parameter int CNT_W    = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  uart_xmit_if.slave  bus
);

  tx_state_t r_state, w_state_nxt;
  logic [7:0] r_sr, w_sr_nxt;
  logic       r_par, w_par_nxt;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic       r_txd, w_txd_nxt;
  logic       r_rdy, w_rdy_nxt;
  logic       r_busy;
  logic       w_tick;
  logic       w_accept;
  logic [7:0] w_din;
  logic       w_unused_din;

`ifdef UART_XMIT_HOLD_REG_EN
  logic [7:0] r_hold, w_hold_nxt;
  logic       r_hold_par, w_hold_par_nxt;
  logic       r_hold_full, w_hold_full_nxt;
`endif

  assign w_din        = bus.Din[7:0];
  assign w_unused_din = ^bus.Din[31:8];
  assign w_accept     = bus.WR && r_rdy;

  uart_xmit_baud_gen #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_W    (CNT_W)
  ) u_baud (
    .Clock  (Clock),
    .Reset  (Reset),
    .i_clr  (r_state == TxIdle),
    .o_tick (w_tick)
  );

  // Next-state, next line value and data-path updates.
  always_comb begin
    w_state_nxt  = r_state;
    w_sr_nxt     = r_sr;
    w_par_nxt    = r_par;
    w_bitcnt_nxt = r_bitcnt;
    w_txd_nxt    = r_txd;
`ifdef UART_XMIT_HOLD_REG_EN
    w_hold_nxt      = r_hold;
    w_hold_par_nxt  = r_hold_par;
    w_hold_full_nxt = r_hold_full;
`endif
    case (r_state)
      TxIdle: begin
        w_txd_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt  = TxStart;
          w_sr_nxt     = w_din;
          w_par_nxt    = even_parity(w_din);
          w_bitcnt_nxt = '0;
          w_txd_nxt    = 1'b0;
        end
      end
      TxStart: begin
        if (w_tick) begin
          w_state_nxt = TxShift;
          w_txd_nxt   = r_sr[0];
        end
      end
      TxShift: begin
        if (w_tick) begin
          if (r_bitcnt == 3'(UART_DATA_BITS - 1)) begin
            w_state_nxt = TxParity;
            w_txd_nxt   = r_par;
          end else begin
            w_sr_nxt     = r_sr >> 1;
            w_txd_nxt    = r_sr[1];
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end
      end
      TxParity: begin
        if (w_tick) begin
          w_state_nxt = TxStop;
          w_txd_nxt   = 1'b1;
        end
      end
      TxStop: begin
        if (w_tick) begin
          w_state_nxt = TxIdle;
          w_txd_nxt   = 1'b1;
`ifdef UART_XMIT_HOLD_REG_EN
          // Chain straight into the next frame; a write landing on this very
          // tick (holding register empty) is taken directly as well.
          if (r_hold_full) begin
            w_state_nxt     = TxStart;
            w_sr_nxt        = r_hold;
            w_par_nxt       = r_hold_par;
            w_bitcnt_nxt    = '0;
            w_txd_nxt       = 1'b0;
            w_hold_full_nxt = 1'b0;
          end else if (w_accept) begin
            w_state_nxt  = TxStart;
            w_sr_nxt     = w_din;
            w_par_nxt    = even_parity(w_din);
            w_bitcnt_nxt = '0;
            w_txd_nxt    = 1'b0;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = TxIdle;
        w_txd_nxt   = 1'b1;
      end
    endcase
`ifdef UART_XMIT_HOLD_REG_EN
    if (w_accept && (r_state != TxIdle) && !((r_state == TxStop) && w_tick)) begin
      w_hold_nxt      = w_din;
      w_hold_par_nxt  = even_parity(w_din);
      w_hold_full_nxt = 1'b1;
    end
    w_rdy_nxt = !w_hold_full_nxt;
`else
    w_rdy_nxt = (w_state_nxt == TxIdle);
`endif
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= TxIdle;
      r_sr     <= '0;
      r_par    <= 1'b0;
      r_bitcnt <= '0;
      r_txd    <= 1'b1;
      r_rdy    <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sr     <= w_sr_nxt;
      r_par    <= w_par_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_txd    <= w_txd_nxt;
      r_rdy    <= w_rdy_nxt;
      r_busy   <= (w_state_nxt != TxIdle);
    end
  end

`ifdef UART_XMIT_HOLD_REG_EN
  // Holding register for the byte queued behind the current frame.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_hold      <= '0;
      r_hold_par  <= 1'b0;
      r_hold_full <= 1'b0;
    end else begin
      r_hold      <= w_hold_nxt;
      r_hold_par  <= w_hold_par_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end
`endif

  assign bus.TxD    = r_txd;
  assign bus.TxRDY  = r_rdy;
  assign bus.TxBusy = r_busy;

endmodule

// File: tb/tb_uart_xmit.sv
// Self-checking bench for uart_xmit at BAUD_DIV=4. Expected line waveforms
// are built from the frame rules (start, data LSB-first, even parity, stop).
module tb_uart_xmit;

  localparam int BD = 4;
  localparam int FRAME_CYC = 11 * BD;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  uart_xmit_if bus ();

  uart_xmit #(
    .BAUD_DIV (BD),
    .CNT_W    (4)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Line bits of one frame, index 0 = start bit, 10 = stop bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = logic'(ones % 2);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle_txd", 32'(bus.TxD), 32'd1);
      check_val("idle_rdy", 32'(bus.TxRDY), 32'd1);
      check_val("idle_busy", 32'(bus.TxBusy), 32'd0);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(bus.TxRDY === 1'b1 && bus.TxBusy === 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_val("ready_timeout", 32'd0, 32'd1);
  endtask

  // One frame with WR driven at the current negedge; optional extra WR at
  // frame cycle wr_cyc with data wr2 (should be ignored when no holding reg).
  task automatic send_and_check(input logic [31:0] din, input int wr_cyc, input logic [31:0] wr2);
    logic [10:0] bits;
    bits = frame_bits(din[7:0]);
    wait_ready();
    bus.WR  = 1'b1;
    bus.Din = din;
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      bus.WR = 1'b0;
      check_val("txd", 32'(bus.TxD), 32'(bits[c / BD]));
      check_val("busy", 32'(bus.TxBusy), 32'd1);
`ifdef UART_XMIT_HOLD_REG_EN
      check_val("rdy", 32'(bus.TxRDY), 32'd1);
`else
      check_val("rdy", 32'(bus.TxRDY), 32'd0);
`endif
      if (c == wr_cyc) begin
        bus.WR  = 1'b1;
        bus.Din = wr2;
      end
    end
    @(negedge clk);
    bus.WR = 1'b0;
    check_val("end_txd", 32'(bus.TxD), 32'd1);
    check_val("end_busy", 32'(bus.TxBusy), 32'd0);
    check_val("end_rdy", 32'(bus.TxRDY), 32'd1);
  endtask

`ifdef UART_XMIT_HOLD_REG_EN
  task automatic hold_check(input logic [7:0] d1, input logic [7:0] d2, input int wr_cyc);
    logic [10:0] b1;
    logic [10:0] b2;
    logic        exp_txd;
    b1 = frame_bits(d1);
    b2 = frame_bits(d2);
    wait_ready();
    bus.WR  = 1'b1;
    bus.Din = {24'h0, d1};
    for (int c = 0; c < 2 * FRAME_CYC; c++) begin
      @(negedge clk);
      bus.WR = 1'b0;
      exp_txd = (c < FRAME_CYC) ? b1[c / BD] : b2[(c - FRAME_CYC) / BD];
      check_val("hold_txd", 32'(bus.TxD), 32'(exp_txd));
      check_val("hold_busy", 32'(bus.TxBusy), 32'd1);
      check_val("hold_rdy", 32'(bus.TxRDY), (c > wr_cyc && c < FRAME_CYC) ? 32'd0 : 32'd1);
      if (c == wr_cyc) begin
        bus.WR  = 1'b1;
        bus.Din = {24'h0, d2};
      end
    end
    @(negedge clk);
    bus.WR = 1'b0;
    check_val("hold_end_busy", 32'(bus.TxBusy), 32'd0);
    check_val("hold_end_txd", 32'(bus.TxD), 32'd1);
  endtask
`endif

  initial begin
    logic [10:0] bits;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.WR   = 1'b0;
    bus.Din  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_txd", 32'(bus.TxD), 32'd1);
    check_val("rst_rdy", 32'(bus.TxRDY), 32'd1);
    check_val("rst_busy", 32'(bus.TxBusy), 32'd0);
    rst_n = 1'b1;
    idle_check(100);

    send_and_check(32'h0000_0055, -1, 32'h0);
    send_and_check(32'hFFFF_FFA7, -1, 32'h0);
    for (int k = 0; k < 8; k++) send_and_check($urandom(), -1, 32'h0);

`ifdef UART_XMIT_HOLD_REG_EN
    hold_check(8'h55, 8'hA7, 10);
    hold_check(8'h00, 8'hFF, FRAME_CYC - 2);
`else
    send_and_check(32'h0000_003C, 17, 32'h0000_00FF);
    idle_check(3 * BD);
`endif

    // Reset during data bit 3 (line bit 4), then a clean frame.
    bits = frame_bits(8'hC9);
    wait_ready();
    bus.WR  = 1'b1;
    bus.Din = 32'h0000_00C9;
    for (int c = 0; c < 4 * BD + 2; c++) begin
      @(negedge clk);
      bus.WR = 1'b0;
      check_val("pre_rst_txd", 32'(bus.TxD), 32'(bits[c / BD]));
    end
    rst_n = 1'b0;
    #1;
    check_val("midrst_txd", 32'(bus.TxD), 32'd1);
    check_val("midrst_rdy", 32'(bus.TxRDY), 32'd1);
    check_val("midrst_busy", 32'(bus.TxBusy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(2 * BD);
    send_and_check(32'h0000_0096, -1, 32'h0);
    idle_check(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
